// File: rtl/mem_pkg.sv
// Shared constants and types for the banked row memory (default geometry).
package mem_pkg;
  localparam int DEF_SIZE      = 7;
  localparam int DEF_MEM_LOG2  = 12;
  localparam int DEF_BANK_LOG2 = 2;
  localparam int DEF_ID_W      = 4;
  localparam int DEF_RSP_DEPTH = 2;

  localparam int ROW_BYTES = 2**DEF_SIZE;
  localparam int ROWS      = 2**(DEF_MEM_LOG2 - DEF_SIZE);
  localparam int BANK_ROWS = ROWS >> DEF_BANK_LOG2;

  typedef logic [ROW_BYTES-1:0][7:0] row_t;
  typedef logic [ROW_BYTES-1:0]      strb_t;

  typedef struct packed {
    logic                we;
    logic [DEF_ID_W-1:0] id;
    row_t                rdata;
  } rsp_t;
endpackage

// File: rtl/mem_bank_ram.sv
// One bank: byte-masked row write, registered row read, contents never reset.
module mem_bank_ram import mem_pkg::*; #(
  parameter int RB     = ROW_BYTES,
  parameter int ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  cs,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     bank_row,
  input  logic [RB-1:0][7:0]    wdata,
  input  logic [RB-1:0]         wstrb,
  output logic [RB-1:0][7:0]    rdata
);
  logic [RB-1:0][7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (cs && we) begin
      for (int i = 0; i < RB; i++)
        if (wstrb[i]) mem[bank_row][i] <= wdata[i];
    end
    if (cs && !we) rdata <= mem[bank_row];
  end
endmodule

// File: rtl/mem_bank_array.sv
// Row-interleaved banked memory with in-order response FIFO and credit flow control.
module mem_bank_array import mem_pkg::*; #(
  parameter int SIZE      = DEF_SIZE,
  parameter int MEM_LOG2  = DEF_MEM_LOG2,
  parameter int BANK_LOG2 = DEF_BANK_LOG2,
  parameter int ID_W      = DEF_ID_W,
  parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [MEM_LOG2-1:0]      req_addr,
  input  logic [(2**SIZE)*8-1:0]   req_wdata,
  input  logic [2**SIZE-1:0]       req_wstrb,
  input  logic [ID_W-1:0]          req_id,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_we,
  output logic [ID_W-1:0]          rsp_id,
  output logic [(2**SIZE)*8-1:0]   rsp_rdata
);
  localparam int NB   = 2**BANK_LOG2;
  localparam int RB   = 2**SIZE;
  localparam int BR_W = MEM_LOG2 - SIZE - BANK_LOG2;
  localparam int PW   = $clog2(RSP_DEPTH);
  localparam int CW   = $clog2(RSP_DEPTH + 1);

  typedef logic [RB-1:0][7:0] lrow_t;
  typedef struct packed {
    logic            we;
    logic [ID_W-1:0] id;
    lrow_t           rdata;
  } ent_t;

  logic                 acc, push, pop, unused_lo;
  logic [BANK_LOG2-1:0] bank;
  logic [BR_W-1:0]      bank_row;
  logic                 if_vld, if_we;
  logic [ID_W-1:0]      if_id;
  logic [BANK_LOG2-1:0] if_bank;
  lrow_t [NB-1:0]       bank_rdata;
  ent_t                 fifo [RSP_DEPTH];
  logic [PW-1:0]        wptr, rptr;
  logic [CW-1:0]        count;
  logic [CW:0]          used;

  assign bank      = req_addr[SIZE +: BANK_LOG2];
  assign bank_row  = req_addr[MEM_LOG2-1 : SIZE+BANK_LOG2];
  assign unused_lo = ^req_addr[SIZE-1:0];

  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign push      = if_vld;
  // A slot freed by this cycle's pop is reusable now, giving full rate at depth 2.
  assign used      = (CW+1)'(count) + (CW+1)'(if_vld) - (CW+1)'(pop);
  assign req_ready = !rst && (used < (CW+1)'(RSP_DEPTH));
  assign acc       = req_valid && req_ready;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    mem_bank_ram #(.RB(RB), .ADDR_W(BR_W)) u_ram (
      .clk      (clk),
      .cs       (acc && (bank == BANK_LOG2'(b))),
      .we       (req_we),
      .bank_row (bank_row),
      .wdata    (req_wdata),
      .wstrb    (req_wstrb),
      .rdata    (bank_rdata[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_vld  <= 1'b0;
      if_we   <= 1'b0;
      if_id   <= '0;
      if_bank <= '0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
    end else begin
      if_vld <= acc;
      if (acc) begin
        if_we   <= req_we;
        if_id   <= req_id;
        if_bank <= bank;
      end
      if (push) wptr <= (wptr == PW'(RSP_DEPTH-1)) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == PW'(RSP_DEPTH-1)) ? '0 : rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo[wptr].we    <= if_we;
      fifo[wptr].id    <= if_id;
      fifo[wptr].rdata <= if_we ? '0 : bank_rdata[if_bank];
    end
  end

  // Outputs read as zero whenever the queue is empty.
  always_comb begin
    rsp_we    = 1'b0;
    rsp_id    = '0;
    rsp_rdata = '0;
    if (rsp_valid) begin
      rsp_we    = fifo[rptr].we;
      rsp_id    = fifo[rptr].id;
      rsp_rdata = fifo[rptr].rdata;
    end
  end
endmodule
